// File: rtl/ctl_formation.sv
// ctl_formation: march-pattern motion generator for the enemy formation base position
module ctl_formation #(
    parameter int X_START   = 100,
    parameter int Y_START   = 60,
    parameter int X_MIN     = 20,
    parameter int X_MAX     = 120,
    parameter int STEP_X    = 4,
    parameter int STEP_DOWN = 16,
    parameter int Y_LIMIT   = 500,
    parameter int FRAME_DIV = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        freeze,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        moving_right,
    output logic        landed
);
    localparam int DW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [2:0] {IDLE, MOVE_RIGHT, DOWN_R, MOVE_LEFT, DOWN_L, LANDED} state_t;

    state_t        state, state_n;
    logic [10:0]   x_n, y_n;
    logic [DW-1:0] div, div_n;
    logic          mr_n;
    logic [11:0]   x_add, x_diff, y_add;
    logic          motion, reload, upd;

    // next-state, next-position and divider logic; start beats freeze beats update
    always_comb begin
        x_add   = {1'b0, x_out} + 12'(STEP_X);
        x_diff  = {1'b0, x_out} - 12'(X_MIN);
        y_add   = {1'b0, y_out} + 12'(STEP_DOWN);
        motion  = state inside {MOVE_RIGHT, DOWN_R, MOVE_LEFT, DOWN_L};
        reload  = start && !motion;
        upd     = frame_tick && div == DW'(FRAME_DIV - 1);
        state_n = state;
        x_n     = x_out;
        y_n     = y_out;
        div_n   = motion ? div : '0;
        if (reload) begin
            state_n = MOVE_RIGHT;
            x_n     = 11'(X_START);
            y_n     = 11'(Y_START);
            div_n   = '0;
        end else if (motion && !freeze && frame_tick) begin
            div_n = upd ? '0 : div + 1'b1;
            if (upd) begin
                case (state)
                    MOVE_RIGHT: begin
                        x_n     = x_add >= 12'(X_MAX) ? 11'(X_MAX) : x_add[10:0];
                        state_n = x_add >= 12'(X_MAX) ? DOWN_R : MOVE_RIGHT;
                    end
                    MOVE_LEFT: begin
                        x_n     = x_diff <= 12'(STEP_X) ? 11'(X_MIN) : x_out - 11'(STEP_X);
                        state_n = x_diff <= 12'(STEP_X) ? DOWN_L : MOVE_LEFT;
                    end
                    DOWN_R, DOWN_L: begin
                        y_n     = y_add >= 12'(Y_LIMIT) ? 11'(Y_LIMIT) : y_add[10:0];
                        state_n = y_add >= 12'(Y_LIMIT) ? LANDED :
                                  state == DOWN_R ? MOVE_LEFT : MOVE_RIGHT;
                    end
                    default: ;
                endcase
            end
        end
        mr_n = (state_n == MOVE_RIGHT || state_n == DOWN_R) ? 1'b1 :
               (state_n == MOVE_LEFT  || state_n == DOWN_L) ? 1'b0 : moving_right;
    end

    // registered state and outputs so direction/landed flip with the state
    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            x_out        <= 11'(X_START);
            y_out        <= 11'(Y_START);
            div          <= '0;
            moving_right <= 1'b1;
            landed       <= 1'b0;
        end else begin
            state        <= state_n;
            x_out        <= x_n;
            y_out        <= y_n;
            div          <= div_n;
            moving_right <= mr_n;
            landed       <= state_n == LANDED;
        end
    end
endmodule
